// File: rtl/control_sequencer_if.sv
// Strobe and handshake bundle between the control sequencer
// and the mini-src datapath / memory.
interface control_sequencer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_COUNT    = 16,
  parameter int ALU_OP_WIDTH = 5
);
  logic                    Run;
  logic                    Stop;
  logic                    MemDone;
  logic [DATA_WIDTH-1:0]   IR;

  logic                    PCout;
  logic                    ZLOout;
  logic                    ZHIout;
  logic                    MDRout;
  logic                    MARin;
  logic                    Zin;
  logic                    PCin;
  logic                    MDRin;
  logic                    IRin;
  logic                    Yin;
  logic                    LOin;
  logic                    HIin;
  logic                    IncrementPC;
  logic                    Read;
  logic [ALU_OP_WIDTH-1:0] ALUControl;
  logic [REG_COUNT-1:0]    Rin;
  logic [REG_COUNT-1:0]    Rout;
  logic                    Halted;
  logic                    Fault;
  logic                    IllegalOp;
  logic [3:0]              State;

  modport master (
    input  Run, Stop, MemDone, IR,
    output PCout, ZLOout, ZHIout, MDRout,
    output MARin, Zin, PCin, MDRin, IRin,
    output Yin, LOin, HIin,
    output IncrementPC, Read, ALUControl,
    output Rin, Rout,
    output Halted, Fault, IllegalOp, State
  );

  modport slave (
    output Run, Stop, MemDone, IR,
    input  PCout, ZLOout, ZHIout, MDRout,
    input  MARin, Zin, PCin, MDRin, IRin,
    input  Yin, LOin, HIin,
    input  IncrementPC, Read, ALUControl,
    input  Rin, Rout,
    input  Halted, Fault, IllegalOp, State
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the mini-src datapath:
// Moore strobes, memory-done wait with timeout, HI/LO two-word ops.
module control_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 16,
  parameter int REG_SEL_WIDTH = 4,
  parameter int ALU_OP_WIDTH  = 5,
  parameter int MEM_TIMEOUT   = 15
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master bus
);

  localparam int RSW   = REG_SEL_WIDTH;
  localparam int RA_HI = DATA_WIDTH - 6;
  localparam int RB_HI = RA_HI - RSW;
  localparam int RC_HI = RB_HI - RSW;
  localparam int LO_HI = RC_HI - RSW;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    FETCH2 = 4'd3,
    EXEC3  = 4'd4,
    EXEC4  = 4'd5,
    EXEC5  = 4'd6,
    EXEC6  = 4'd7,
    HALT   = 4'd8,
    FAULT  = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    K_ALU,
    K_MULDIV,
    K_NOP,
    K_HALT,
    K_ILLEGAL
  } kind_t;

  state_t           state;
  state_t           boundary;
  logic [7:0]       wait_cnt;
  logic             first_q;
  kind_t            kind_q;
  logic             bad_q;
  logic [4:0]       op_q;
  logic [RSW-1:0]   ra_q;
  logic [RSW-1:0]   rc_q;

  logic [4:0]       ir_op;
  logic [RSW-1:0]   ir_ra;
  logic [RSW-1:0]   ir_rb;
  logic [RSW-1:0]   ir_rc;
  kind_t            kind_d;
  logic             bad_d;
  logic             unused_ir;

  assign ir_op     = bus.IR[DATA_WIDTH-1 -: 5];
  assign ir_ra     = bus.IR[RA_HI -: RSW];
  assign ir_rb     = bus.IR[RB_HI -: RSW];
  assign ir_rc     = bus.IR[RC_HI -: RSW];
  assign unused_ir = ^bus.IR[LO_HI:0];

  function automatic kind_t kind_of(
    input logic [4:0] op
  );
    kind_t k;
    k = K_ILLEGAL;
    unique case (1'b1)
      (op < 5'd16):   k = K_ALU;
      (op == 5'd16),
      (op == 5'd17):  k = K_MULDIV;
      (op == 5'd26):  k = K_NOP;
      (op == 5'd27):  k = K_HALT;
      default:        k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  function automatic logic idx_bad(
    input logic [RSW-1:0] idx
  );
    return 32'(idx) >= 32'(REG_COUNT);
  endfunction

  function automatic logic [REG_COUNT-1:0] onehot(
    input logic [RSW-1:0] idx,
    input logic           en
  );
    logic [REG_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      v[i] = en && (32'(idx) == 32'(i));
    end
    return v;
  endfunction

  assign kind_d = kind_of(ir_op);

  // Only fields the instruction actually uses can make it bad.
  always_comb begin
    bad_d = 1'b0;
    unique case (kind_d)
      K_ALU:    bad_d = idx_bad(ir_ra) ||
                        idx_bad(ir_rb) ||
                        idx_bad(ir_rc);
      K_MULDIV: bad_d = idx_bad(ir_rb) ||
                        idx_bad(ir_rc);
      default:  bad_d = 1'b0;
    endcase
  end

  assign boundary = (bus.Stop || !bus.Run)
                  ? IDLE : FETCH0;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      first_q  <= 1'b0;
      kind_q   <= K_NOP;
      bad_q    <= 1'b0;
      op_q     <= '0;
      ra_q     <= '0;
      rc_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Run) state <= FETCH0;
        end
        FETCH0: begin
          state    <= FETCH1;
          wait_cnt <= '0;
          first_q  <= 1'b1;
        end
        FETCH1: begin
          first_q <= 1'b0;
          if (bus.MemDone) begin
            state <= FETCH2;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == 8'(MEM_TIMEOUT - 1))
              state <= FAULT;
          end
        end
        FETCH2: state <= EXEC3;
        EXEC3: begin
          kind_q <= kind_d;
          bad_q  <= bad_d;
          op_q   <= ir_op;
          ra_q   <= ir_ra;
          rc_q   <= ir_rc;
          unique case (kind_d)
            K_ALU,
            K_MULDIV: state <= EXEC4;
            K_HALT:   state <= HALT;
            default:  state <= boundary;
          endcase
        end
        EXEC4: state <= EXEC5;
        EXEC5: begin
          if (kind_q == K_MULDIV) state <= EXEC6;
          else                    state <= boundary;
        end
        EXEC6: state <= boundary;
        HALT:  state <= HALT;
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the registered state; IR is datapath state.
  always_comb begin
    bus.PCout       = 1'b0;
    bus.ZLOout      = 1'b0;
    bus.ZHIout      = 1'b0;
    bus.MDRout      = 1'b0;
    bus.MARin       = 1'b0;
    bus.Zin         = 1'b0;
    bus.PCin        = 1'b0;
    bus.MDRin       = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.LOin        = 1'b0;
    bus.HIin        = 1'b0;
    bus.IncrementPC = 1'b0;
    bus.Read        = 1'b0;
    bus.ALUControl  = '0;
    bus.Rin         = '0;
    bus.Rout        = '0;
    bus.Halted      = 1'b0;
    bus.Fault       = 1'b0;
    bus.IllegalOp   = 1'b0;
    unique case (state)
      FETCH0: begin
        bus.PCout       = 1'b1;
        bus.MARin       = 1'b1;
        bus.IncrementPC = 1'b1;
        bus.Zin         = 1'b1;
      end
      FETCH1: begin
        bus.ZLOout = first_q;
        bus.PCin   = first_q;
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
      end
      FETCH2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      EXEC3: begin
        if (kind_d == K_ALU || kind_d == K_MULDIV) begin
          bus.Rout = onehot(ir_rb, !bad_d);
          bus.Yin  = 1'b1;
        end
        bus.IllegalOp = (kind_d == K_ILLEGAL) || bad_d;
      end
      EXEC4: begin
        bus.Rout       = onehot(rc_q, !bad_q);
        bus.Zin        = 1'b1;
        bus.ALUControl = ALU_OP_WIDTH'(op_q);
      end
      EXEC5: begin
        bus.ZLOout = 1'b1;
        if (kind_q == K_MULDIV) bus.LOin = 1'b1;
        else bus.Rin = onehot(ra_q, !bad_q);
      end
      EXEC6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      HALT:    bus.Halted = 1'b1;
      FAULT:   bus.Fault  = 1'b1;
      default: ;
    endcase
  end

  assign bus.State = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: per-cycle
// expected strobes are queued, then popped and checked.
module tb_control_sequencer;

  logic Clock;
  logic Clear;

  control_sequencer_if #(
    .DATA_WIDTH(32),
    .REG_COUNT(16),
    .ALU_OP_WIDTH(5)
  ) bus ();

  control_sequencer #(
    .DATA_WIDTH(32),
    .REG_COUNT(16),
    .REG_SEL_WIDTH(4),
    .ALU_OP_WIDTH(5),
    .MEM_TIMEOUT(15)
  ) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [16:0] PCO = 17'h10000;
  localparam logic [16:0] ZLO = 17'h08000;
  localparam logic [16:0] ZHI = 17'h04000;
  localparam logic [16:0] MDO = 17'h02000;
  localparam logic [16:0] MAR = 17'h01000;
  localparam logic [16:0] ZIN = 17'h00800;
  localparam logic [16:0] PCI = 17'h00400;
  localparam logic [16:0] MDI = 17'h00200;
  localparam logic [16:0] IRI = 17'h00100;
  localparam logic [16:0] YIN = 17'h00080;
  localparam logic [16:0] LOI = 17'h00040;
  localparam logic [16:0] HII = 17'h00020;
  localparam logic [16:0] INC = 17'h00010;
  localparam logic [16:0] RD  = 17'h00008;
  localparam logic [16:0] HLT = 17'h00004;
  localparam logic [16:0] FLT = 17'h00002;
  localparam logic [16:0] ILL = 17'h00001;

  localparam logic [16:0] F0  = PCO | MAR | INC | ZIN;
  localparam logic [16:0] F1A = ZLO | PCI | RD | MDI;
  localparam logic [16:0] F1  = RD | MDI;
  localparam logic [16:0] F2  = MDO | IRI;

  localparam logic [31:0] I_ADD  = 32'h2891_8000;
  localparam logic [31:0] I_MUL  = 32'h8091_8000;
  localparam logic [31:0] I_BAD  = 32'hF000_0000;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] sb;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  alu;
    logic        md;
    logic        run;
    logic        stop;
    logic [31:0] ir;
  } exp_t;

  exp_t        sbq[$];
  logic        run_n;
  logic        stop_n;
  logic [31:0] ir_n;
  int          n_chk;
  int          n_fail;

  function automatic logic [57:0] snap();
    return {bus.State,
            bus.PCout, bus.ZLOout, bus.ZHIout,
            bus.MDRout, bus.MARin, bus.Zin,
            bus.PCin, bus.MDRin, bus.IRin,
            bus.Yin, bus.LOin, bus.HIin,
            bus.IncrementPC, bus.Read,
            bus.Halted, bus.Fault, bus.IllegalOp,
            bus.Rout, bus.Rin, bus.ALUControl};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [57:0] obs,
    input logic [57:0] expv
  );
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, expv);
    end
  endtask

  task automatic push(
    input logic [3:0]  st,
    input logic [16:0] sb,
    input logic [15:0] ro,
    input logic [15:0] ri,
    input logic [4:0]  alu,
    input logic        md
  );
    exp_t e;
    e.st   = st;
    e.sb   = sb;
    e.ro   = ro;
    e.ri   = ri;
    e.alu  = alu;
    e.md   = md;
    e.run  = run_n;
    e.stop = stop_n;
    e.ir   = ir_n;
    sbq.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    int   k;
    k = 0;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge Clock);
      chk($sformatf("%s/c%0d", tag, k), snap(),
          {e.st, e.sb, e.ro, e.ri, e.alu});
      bus.Run     = e.run;
      bus.Stop    = e.stop;
      bus.MemDone = e.md;
      bus.IR      = e.ir;
      k++;
    end
  endtask

  task automatic pulse_clear(input string tag);
    @(negedge Clock);
    Clear = 1'b1;
    #1;
    chk(tag, snap(), 58'd0);
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    Clear       = 1'b1;
    bus.Run     = 1'b0;
    bus.Stop    = 1'b0;
    bus.MemDone = 1'b0;
    bus.IR      = '0;
    run_n       = 1'b1;
    stop_n      = 1'b0;
    ir_n        = '0;

    pulse_clear("reset");
    bus.Run = 1'b1;

    // ADD R1,R2,R3 then MUL back to back
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_ADD;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, YIN, 16'h4, 16'h0, 5'd0, 1'b0);
    push(4'd5, ZIN, 16'h8, 16'h0, 5'd5, 1'b0);
    push(4'd6, ZLO, 16'h0, 16'h2, 5'd0, 1'b0);
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_MUL;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, YIN, 16'h4, 16'h0, 5'd0, 1'b0);
    push(4'd5, ZIN, 16'h8, 16'h0, 5'd16, 1'b0);
    push(4'd6, ZLO | LOI, 16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd7, ZHI | HII, 16'h0, 16'h0, 5'd0, 1'b0);
    // Illegal opcode with MemDone three cycles late
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1,  16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_BAD;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, ILL, 16'h0, 16'h0, 5'd0, 1'b0);
    // NOP
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_NOP;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, 17'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    // ADD with Stop raised in EXEC3
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_ADD;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    stop_n = 1'b1;
    push(4'd4, YIN, 16'h4, 16'h0, 5'd0, 1'b0);
    push(4'd5, ZIN, 16'h8, 16'h0, 5'd5, 1'b0);
    push(4'd6, ZLO, 16'h0, 16'h2, 5'd0, 1'b0);
    stop_n = 1'b0;
    push(4'd0, 17'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    // HALT holds with Run high
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_HALT;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, 17'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd8, HLT, 16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd8, HLT, 16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd8, HLT, 16'h0, 16'h0, 5'd0, 1'b0);
    drain("seq");

    pulse_clear("clr_halt");

    // MemDone never arrives: 15 FETCH1 cycles then FAULT
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b0);
    for (int i = 0; i < 14; i++)
      push(4'd2, F1, 16'h0, 16'h0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      push(4'd9, FLT, 16'h0, 16'h0, 5'd0, 1'b0);
    drain("tmo");

    pulse_clear("clr_fault");

    // Clear asserted while in EXEC4
    ir_n = 32'h0;
    push(4'd1, F0,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd2, F1A, 16'h0, 16'h0, 5'd0, 1'b1);
    ir_n = I_ADD;
    push(4'd3, F2,  16'h0, 16'h0, 5'd0, 1'b0);
    push(4'd4, YIN, 16'h4, 16'h0, 5'd0, 1'b0);
    drain("abort");
    @(posedge Clock);
    #2;
    chk("exec4", snap(),
        {4'd5, ZIN, 16'h8, 16'h0, 5'd5});
    Clear = 1'b1;
    #1;
    chk("async_clr", snap(), 58'd0);
    @(posedge Clock);
    #1;
    chk("clr_hold", snap(), 58'd0);
    @(negedge Clock);
    Clear   = 1'b0;
    bus.Run = 1'b0;
    @(negedge Clock);
    chk("idle_norun", snap(), 58'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
